bram_debug_loader: RTL and testbench

- Synthesizable command-driven sequencer that drives the block-RAM debug ports (A2/WD2/WE2/RD2) of `RV32Core`.
- Loads word streams into any of `NUM_CH` RAMs and dumps RAM contents back out as a stream.
- Holds the core in reset except during a bounded run window of programmable length.
- Replaces fixed-path, fixed-delay bench sequencing with a parametrised engine usable in simulation and on the board (e.g. behind a UART bridge).

---
 rtl/bram_debug_loader_if.sv | 45 ++++
 rtl/bram_debug_loader.sv | 163 ++++++++++++++++
 tb/tb_bram_debug_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_debug_loader_if.sv
// Command, load-stream, dump-stream and RAM debug-port bundle for bram_debug_loader.
// slave  = the loader itself, master = whoever issues commands and owns the RAMs.
interface bram_debug_loader_if #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4096,
    parameter int NUM_CH = 2,
    parameter int CW     = $clog2(WORDS) + 1,
    parameter int SW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [SW-1:0]              cmd_ch;
    logic [CW-1:0]              cmd_count;
    logic [31:0]                cmd_cycles;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [31:0]                out_addr;
    logic [NUM_CH*32-1:0]       dbg_a2;
    logic [NUM_CH*DATA_W-1:0]   dbg_wd2;
    logic [NUM_CH*DATA_W/8-1:0] dbg_we2;
    logic [NUM_CH*DATA_W-1:0]   dbg_rd2;
    logic                       core_rst;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_ch, cmd_count, cmd_cycles,
        input  in_valid, in_data, out_ready, dbg_rd2,
        output cmd_ready, in_ready, out_valid, out_data, out_addr,
        output dbg_a2, dbg_wd2, dbg_we2, core_rst, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_ch, cmd_count, cmd_cycles,
        output in_valid, in_data, out_ready, dbg_rd2,
        input  cmd_ready, in_ready, out_valid, out_data, out_addr,
        input  dbg_a2, dbg_wd2, dbg_we2, core_rst, busy, done, err
    );
endinterface

// File: rtl/bram_debug_loader.sv
// Command-driven sequencer for the RV32Core block-RAM debug ports: streams words
// into a RAM, dumps a RAM back out, and releases core reset for a bounded window.
module bram_debug_loader #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4096,
    parameter int NUM_CH = 2,
    parameter int CW     = $clog2(WORDS) + 1,
    parameter int SW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               CPU_CLK,
    input  logic               CPU_RST_N,
    bram_debug_loader_if.slave bus
);
    localparam int            BYTES   = DATA_W / 8;
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [1:0]    OP_LOAD = 2'b00;
    localparam logic [1:0]    OP_DUMP = 2'b01;
    localparam logic [1:0]    OP_RUN  = 2'b10;
    localparam logic [1:0]    OP_NOP  = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, RUN, FIN} state_t;
    state_t state, stateNext;

    logic [SW-1:0]     chQ;
    logic [CW-1:0]     nQ, idx;
    logic [31:0]       cycCnt;
    logic              cmdReadyQ, outValidQ, coreRstQ, errQ, weQ;
    logic [31:0]       addrQ, outAddrQ;
    logic [DATA_W-1:0] wdQ, outDataQ, rdSel;
    logic              accept, chOk, beat, outFire, lastWord;
    logic [CW-1:0]     nClamp;
    logic [1:0]        opEff;
    logic              inReady, busyC, doneC;

    function automatic logic [31:0] byteAddr(input logic [CW-1:0] i);
        return 32'(i) * 32'(BYTES);
    endfunction

    // cmd_ready is registered, so it is only 1 while the FSM sits in IDLE
    assign accept   = bus.cmd_valid && cmdReadyQ;
    assign chOk     = int'(bus.cmd_ch) < NUM_CH;
    assign opEff    = chOk ? bus.cmd_op : OP_NOP;
    assign nClamp   = (bus.cmd_count > WORDS_C) ? WORDS_C : bus.cmd_count;
    assign beat     = bus.in_valid && inReady;
    assign outFire  = (state == DUMP_OUT) && outValidQ && bus.out_ready;
    assign lastWord = (idx + ONE) >= nQ;

    // State register
    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) state <= IDLE;
        else            state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) begin
                case (opEff)
                    OP_LOAD: stateNext = (nClamp == '0) ? FIN : LOAD;
                    OP_DUMP: stateNext = (nClamp == '0) ? FIN : DUMP_ADDR;
                    OP_RUN:  stateNext = RUN;
                    default: stateNext = FIN;
                endcase
            end
            LOAD:      if (beat && lastWord) stateNext = FIN;
            DUMP_ADDR: stateNext = DUMP_WAIT;
            DUMP_WAIT: stateNext = DUMP_OUT;
            DUMP_OUT:  if (outFire) stateNext = lastWord ? FIN : DUMP_ADDR;
            RUN:       if (cycCnt == 32'd0) stateNext = FIN;
            FIN:       stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        inReady = (state == LOAD) && (idx < nQ);
        busyC   = (state != IDLE);
        doneC   = (state == FIN);
    end

    // Read-data mux for the selected channel
    always_comb begin
        rdSel = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (chQ == SW'(c)) rdSel = bus.dbg_rd2[c*DATA_W +: DATA_W];
    end

    // Datapath: command latch, write beats, dump capture, run countdown
    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            cmdReadyQ <= 1'b0;
            chQ       <= '0;
            nQ        <= '0;
            idx       <= '0;
            cycCnt    <= '0;
            addrQ     <= '0;
            wdQ       <= '0;
            weQ       <= 1'b0;
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            outAddrQ  <= '0;
            coreRstQ  <= 1'b1;
            errQ      <= 1'b0;
        end else begin
            cmdReadyQ <= (stateNext == IDLE);
            weQ       <= 1'b0;
            if (accept) begin
                chQ    <= bus.cmd_ch;
                nQ     <= nClamp;
                idx    <= '0;
                cycCnt <= bus.cmd_cycles;
                addrQ  <= '0;
                wdQ    <= '0;
                if (!chOk) errQ <= 1'b1;
                if (opEff == OP_RUN && bus.cmd_cycles != 32'd0) coreRstQ <= 1'b0;
            end
            if (beat) begin
                addrQ <= byteAddr(idx);
                wdQ   <= bus.in_data;
                weQ   <= 1'b1;
                idx   <= idx + ONE;
            end
            // RAM saw the address at the end of DUMP_ADDR; data is valid now
            if (state == DUMP_WAIT) begin
                outDataQ  <= rdSel;
                outAddrQ  <= byteAddr(idx);
                outValidQ <= 1'b1;
            end
            if (outFire) begin
                outValidQ <= 1'b0;
                if (!lastWord) begin
                    idx   <= idx + ONE;
                    addrQ <= byteAddr(idx + ONE);
                end
            end
            // core_rst rises as the count hits 0; FIN follows one cycle later
            if (state == RUN && cycCnt != 32'd0) begin
                cycCnt <= cycCnt - 32'd1;
                if (cycCnt == 32'd1) coreRstQ <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmdReadyQ;
    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValidQ;
    assign bus.out_data  = outDataQ;
    assign bus.out_addr  = outAddrQ;
    assign bus.core_rst  = coreRstQ;
    assign bus.busy      = busyC;
    assign bus.done      = doneC;
    assign bus.err       = errQ;

    // Only the latched channel sees address/data/enables; others stay at 0
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign bus.dbg_a2[c*32 +: 32]         = (chQ == SW'(c)) ? addrQ : 32'd0;
        assign bus.dbg_wd2[c*DATA_W +: DATA_W] = (chQ == SW'(c)) ? wdQ : '0;
        assign bus.dbg_we2[c*BYTES +: BYTES]   = {BYTES{weQ && (chQ == SW'(c))}};
    end
endmodule

// File: tb/tb_bram_debug_loader.sv
// Directed bench for bram_debug_loader with a per-channel synchronous RAM model.
// Three channels so that channel select 3 is out of range.
module tb_bram_debug_loader;
    localparam int DATA_W = 32;
    localparam int WORDS  = 4096;
    localparam int NUM_CH = 3;

    logic CPU_CLK = 1'b0;
    logic CPU_RST_N;
    always #5 CPU_CLK = ~CPU_CLK;

    bram_debug_loader_if #(.DATA_W(DATA_W), .WORDS(WORDS), .NUM_CH(NUM_CH)) bus ();

    bram_debug_loader #(.DATA_W(DATA_W), .WORDS(WORDS), .NUM_CH(NUM_CH)) dut (
        .CPU_CLK  (CPU_CLK),
        .CPU_RST_N(CPU_RST_N),
        .bus      (bus)
    );

    logic [31:0] mem   [NUM_CH][WORDS];
    logic [31:0] rdQ   [NUM_CH];
    logic [31:0] lastA [NUM_CH];
    int          wrCnt [NUM_CH];
    int          passCnt = 0, failCnt = 0, checkCnt = 0;
    int          base, lowCnt;
    logic        sawDone;
    logic [31:0] ldData [3] = '{32'h00000013, 32'h00100093, 32'hDEADBEEF};

    // RAM model: byte-enabled write, 1-cycle synchronous read, preload ch1 in reset
    always @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            mem[1][0] <= 32'h11111111;
            mem[1][1] <= 32'h22222222;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.dbg_we2[c*4 +: 4] != 4'h0) begin
                mem[c][bus.dbg_a2[c*32+2 +: 12]] <= bus.dbg_wd2[c*32 +: 32];
                wrCnt[c] <= wrCnt[c] + 1;
                lastA[c] <= bus.dbg_a2[c*32 +: 32];
            end
            rdQ[c] <= mem[c][bus.dbg_a2[c*32+2 +: 12]];
        end
    end

    always_comb begin
        bus.dbg_rd2 = '0;
        for (int c = 0; c < NUM_CH; c++) bus.dbg_rd2[c*32 +: 32] = rdQ[c];
    end

    task automatic step();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        CPU_RST_N      = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b11;
        bus.cmd_ch     = 2'd0;
        bus.cmd_count  = '0;
        bus.cmd_cycles = 32'd0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'd0;
        bus.out_ready  = 1'b0;

        // Reset
        repeat (3) step();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out", {bus.out_valid, bus.out_data, bus.out_addr}, 0);
        chk("rst_dbg", {bus.dbg_a2, bus.dbg_we2}, 0);
        chk("rst_dbg_wd2", bus.dbg_wd2, 0);
        chk("rst_core_rst", bus.core_rst, 1);
        chk("rst_busy_done_err", {bus.busy, bus.done, bus.err}, 0);
        CPU_RST_N = 1'b1;
        chk("ready_at_release", bus.cmd_ready, 0);
        step();
        chk("ready_after_release", bus.cmd_ready, 1);

        // LOAD ch0, 3 back-to-back words
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_ch = 2'd0; bus.cmd_count = 13'd3;
        bus.in_valid  = 1'b1; bus.in_data = ldData[0];
        step();
        bus.cmd_valid = 1'b0;
        chk("load_busy_ready", {bus.busy, bus.cmd_ready, bus.in_ready}, 3'b101);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("load_we_%0d", i), bus.dbg_we2, 12'h00F);
            chk($sformatf("load_a2_%0d", i), bus.dbg_a2[31:0], 32'(4 * i));
            chk($sformatf("load_wd_%0d", i), bus.dbg_wd2[31:0], ldData[i]);
            chk($sformatf("load_other_a2_%0d", i), bus.dbg_a2[95:32], 0);
            if (i < 2) bus.in_data = ldData[i+1];
        end
        chk("load_done", {bus.done, bus.in_ready}, 2'b10);
        bus.in_valid = 1'b0;
        step();
        chk("load_idle", {bus.dbg_we2, bus.done, bus.busy}, 0);
        chk("load_mem0", mem[0][0], 32'h00000013);
        chk("load_mem1", mem[0][1], 32'h00100093);
        chk("load_mem2", mem[0][2], 32'hDEADBEEF);
        chk("load_wrcnt", {wrCnt[0], wrCnt[1], wrCnt[2]}, {32'd3, 32'd0, 32'd0});

        // DUMP ch1, 2 words, out_ready low for 5 cycles on the first word
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_ch = 2'd1; bus.cmd_count = 13'd2;
        step();
        bus.cmd_valid = 1'b0;
        chk("dump_addr_cyc", {bus.out_valid, bus.dbg_a2[63:32]}, 0);
        step();
        chk("dump_wait_cyc", bus.out_valid, 0);
        step();
        chk("dump_word0", {bus.out_valid, bus.out_data, bus.out_addr}, {1'b1, 32'h11111111, 32'h0});
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("dump_hold_%0d", i), {bus.out_valid, bus.out_data, bus.out_addr},
                {1'b1, 32'h11111111, 32'h0});
        end
        bus.out_ready = 1'b1;
        step();
        chk("dump_addr1", {bus.out_valid, bus.dbg_a2[63:32]}, {1'b0, 32'h4});
        step();
        step();
        chk("dump_word1", {bus.out_valid, bus.out_data, bus.out_addr}, {1'b1, 32'h22222222, 32'h4});
        step();
        chk("dump_done", {bus.done, bus.out_valid}, 2'b10);
        bus.out_ready = 1'b0;
        step();
        chk("dump_idle", {bus.busy, bus.done}, 0);

        // RUN 10 cycles
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_cycles = 32'd10;
        step();
        bus.cmd_valid = 1'b0;
        lowCnt = 0;
        for (int i = 0; i < 50 && bus.core_rst == 1'b0; i++) begin
            lowCnt++;
            step();
        end
        chk("run10_low_cycles", lowCnt, 10);
        chk("run10_rise_no_done", {bus.core_rst, bus.done}, 2'b10);
        step();
        chk("run10_done", bus.done, 1);
        step();

        // RUN 0 cycles
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_cycles = 32'd0;
        step();
        bus.cmd_valid = 1'b0;
        chk("run0_c1", {bus.core_rst, bus.done}, 2'b10);
        step();
        chk("run0_c2", {bus.core_rst, bus.done}, 2'b11);
        step();

        // LOAD count clamp
        base = wrCnt[0];
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_ch = 2'd0; bus.cmd_count = 13'd5000;
        bus.in_valid  = 1'b1; bus.in_data = 32'hA5A50000;
        step();
        bus.cmd_valid = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 5000 && !sawDone; i++) begin
            step();
            if (bus.done) sawDone = 1'b1;
        end
        chk("clamp_done_seen", sawDone, 1);
        bus.in_valid = 1'b0;
        step();
        chk("clamp_writes", wrCnt[0] - base, 4096);
        chk("clamp_last_addr", lastA[0], 32'h3FFC);

        // Invalid channel
        chk("err_before", bus.err, 0);
        base = wrCnt[0] + wrCnt[1] + wrCnt[2];
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_ch = 2'd3; bus.cmd_count = 13'd2;
        bus.in_valid  = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        chk("badch_fin", {bus.done, bus.err, bus.in_ready, bus.dbg_we2}, {1'b1, 1'b1, 1'b0, 12'h0});
        step();
        bus.in_valid = 1'b0;
        chk("badch_sticky", {bus.done, bus.err}, 2'b01);
        step();
        chk("badch_no_writes", wrCnt[0] + wrCnt[1] + wrCnt[2] - base, 0);

        // LOAD ch2 count 8, reset after the 4th beat
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_ch = 2'd2; bus.cmd_count = 13'd8;
        bus.in_valid  = 1'b1; bus.in_data = 32'h100;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.in_data = 32'h101 + 32'(i);
        end
        chk("midrst_beat4_we", bus.dbg_we2, 12'hF00);
        CPU_RST_N = 1'b0;
        step();
        chk("midrst_state", {bus.dbg_we2, bus.done, bus.busy, bus.core_rst, bus.err, bus.in_ready},
            {12'h0, 5'b00100});
        CPU_RST_N = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("midrst_idle", {bus.cmd_ready, bus.busy, bus.done}, 3'b100);
        chk("midrst_writes", wrCnt[2], 4);
        chk("midrst_last_word", mem[2][3], 32'h103);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
